rand_candidate_gen: RTL
=======================

# rand_candidate_gen

Downstream consumer of the LFSR pseudo-random stream in the RSA key-generation path. It samples the half-word random output over successive cycles and assembles a full `WORD_WIDTH` prime candidate. It forces the top two bits and the LSB of the candidate to 1, so the candidate is odd and a product of two candidates has full width. The candidate is handed to the primality tester through a valid/ready handshake.

## Interface
- `WORD_WIDTH`, 32: candidate width in bits. Must be even and ≥ 8. Random input is `WORD_WIDTH/2` bits.
- `SAMPLE_GAP`, 1: cycles between the low-half and high-half samples. Must be ≥ 1; 1 means consecutive cycles.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rand_in`  in  `WORD_WIDTH/2`  free-running LFSR output; a new value every cycle.
- `start`  in  1  request one candidate; sampled in IDLE, or in PRESENT on the acceptance cycle.
- `cand_ready`  in  1  consumer ready.
- `cand_valid`  out  1  candidate valid.
- `candidate`  out  `WORD_WIDTH`  assembled candidate.
- `busy`  out  1  high in any state other than IDLE.
- `reject_cnt`  out  16  saturating count of filtered-out candidates.

## Operation
- States: IDLE, GATHER_LO, GATHER_HI, CHECK (present only with the filter compiled in), PRESENT.
- IDLE:
  - `start`=1 → GATHER_LO.
  - Otherwise stay in IDLE.
- GATHER_LO:
  - Capture `rand_in` into `candidate[WORD_WIDTH/2-1:0]` with bit 0 forced to 1.
  - Clear the gap counter and go to GATHER_HI.
- GATHER_HI:
  - While the gap counter < `SAMPLE_GAP-1`, increment it and stay.
  - Otherwise capture `rand_in` into the upper half with bits `WORD_WIDTH-1` and `WORD_WIDTH-2` forced to 1.
  - Then go to CHECK if the filter is compiled in, else to PRESENT.
- CHECK:
  - Compute candidate mod 3 on the forced value.
  - If the residue is 0: increment `reject_cnt` (saturate at 16'hFFFF) and go to GATHER_LO. The retry is automatic; `start` is not needed.
  - Otherwise go to PRESENT.
- PRESENT:
  - `cand_valid`=1. `candidate` is held stable until accepted.
  - On `cand_valid && cand_ready`: go to GATHER_LO if `start`=1 in the same cycle, else go to IDLE.
- `start` is ignored in GATHER_LO, GATHER_HI and CHECK; requests are not queued.
- `candidate` is registered and keeps its last value outside PRESENT. Its value is meaningful only while `cand_valid`=1.
- `reject_cnt` is cleared only by reset.

## Timing
- Reset values: state IDLE, `cand_valid`=0, `busy`=0, `candidate`=0, `reject_cnt`=0, gap counter 0.
- Reset is asynchronous. Asserting it mid-operation drops `cand_valid` immediately and discards any partial candidate.
- Cycle numbering, with `start` seen in IDLE at cycle T:
  - Low half sampled from `rand_in` at the T+1 edge.
  - High half sampled at the T+1+`SAMPLE_GAP` edge.
- `cand_valid` rises at:
  - T+1+`SAMPLE_GAP` without the filter.
  - T+2+`SAMPLE_GAP` with the filter and an accepted candidate.
- Each filter reject adds 1+`SAMPLE_GAP`+1 cycles.
- `cand_valid` is never deasserted without acceptance; the consumer may hold `cand_ready` low indefinitely.
- Back-to-back operation: with `start` and `cand_ready` both high, throughput is one candidate per 2+`SAMPLE_GAP` cycles without the filter.

## Configuration
- Macro `RAND_CAND_DIV3_FILTER_EN`.
- Defined:
  - The CHECK state and the mod-3 screen are present.
  - Multiples of 3 are never presented.
  - `reject_cnt` counts rejects.
- Undefined:
  - No CHECK state; GATHER_HI goes directly to PRESENT.
  - Every assembled candidate is presented.
  - `reject_cnt` is tied to 0.

## Test plan
- Reset check: with `rst_n`=0, all outputs are 0. After release, IDLE with `busy`=0, and `cand_valid` stays 0 with `start`=0.
- Assembly and latency: `WORD_WIDTH`=32, `SAMPLE_GAP`=1, `rand_in` 16'h1230 then 16'h5678 on consecutive sample edges → `candidate`=32'hD678_1231, `cand_valid` at T+2 (filter off) or T+3 (filter on), `reject_cnt`=0.
- Filter reject: `rand_in` 16'h1234 then 16'h5678 gives 32'hD678_1235, which is divisible by 3.
  - Filter on: not presented, `reject_cnt`=1, the block resamples automatically, and the next non-multiple of 3 is presented.
  - Filter off: presented as 32'hD678_1235.
- Gap: `SAMPLE_GAP`=3, `rand_in` incrementing by 1 each cycle starting at 16'h0010 on the T+1 edge → low half 16'h0011, high half sampled at T+4 as 16'h0013 | 16'hC000 → `candidate`=32'hC013_0011.
- Backpressure: hold `cand_ready`=0 for 20 cycles while `rand_in` changes → `cand_valid` and `candidate` stay stable. Assert `cand_ready` together with `start` → the next capture begins the following cycle with no IDLE cycle.
- Reset mid-operation: assert `rst_n`=0 while in GATHER_HI → `cand_valid`=0 and `busy`=0 asynchronously. After release, a new `start` produces a fresh candidate with correct latency.

Source files
------------

// File: rtl/rand_candidate_gen.sv
// rand_candidate_gen
//   Assembles a WORD_WIDTH-bit RSA prime candidate from two half-word
//   samples of a free-running LFSR stream. The top two bits and the LSB
//   are forced to 1, so the candidate is odd and a product of two
//   candidates has full width. The candidate is handed to the primality
//   tester over a valid/ready handshake.
//
// Parameters
//   WORD_WIDTH  candidate width (even, >= 8); rand_in is WORD_WIDTH/2 bits
//   SAMPLE_GAP  cycles between low-half and high-half samples (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rand_in     LFSR output, new value every cycle
//   start       request one candidate (IDLE, or PRESENT on acceptance)
//   cand_ready  consumer ready
//   cand_valid  candidate valid
//   candidate   assembled candidate, held stable while cand_valid
//   busy        high in any state other than IDLE
//   reject_cnt  saturating count of candidates dropped by the mod-3 screen
//
// Build option
//   RAND_CAND_DIV3_FILTER_EN  adds a CHECK state that drops multiples of 3
//                             and retries automatically; without it every
//                             assembled candidate is presented and
//                             reject_cnt is tied to 0.

`timescale 1ns/1ps

module rand_candidate_gen #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned SAMPLE_GAP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_WIDTH/2-1:0] rand_in,
  input  logic                    start,
  input  logic                    cand_ready,
  output logic                    cand_valid,
  output logic [WORD_WIDTH-1:0]   candidate,
  output logic                    busy,
  output logic [15:0]             reject_cnt
);

  localparam int unsigned HALF = WORD_WIDTH / 2;
  localparam int unsigned GW   = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;

  localparam logic [GW-1:0]   GAP_LAST = GW'(SAMPLE_GAP - 1);
  localparam logic [HALF-1:0] LO_FORCE = {{(HALF-1){1'b0}}, 1'b1};
  localparam logic [HALF-1:0] HI_FORCE = {2'b11, {(HALF-2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER_LO,
    S_GATHER_HI,
    S_PRESENT
`ifdef RAND_CAND_DIV3_FILTER_EN
    , S_CHECK
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] cand_q,  cand_d;
  logic [GW-1:0]         gap_q,   gap_d;

`ifdef RAND_CAND_DIV3_FILTER_EN
  logic [15:0] rej_q, rej_d;

  // Residue mod 3 from base-4 digits: 4 == 1 (mod 3), so the residue is
  // the running sum of 2-bit digits folded back into 0..2.
  function automatic logic [1:0] mod3(input logic [WORD_WIDTH-1:0] v);
    logic [1:0] r;
    logic [2:0] s;
    r = '0;
    for (int unsigned i = 0; i < HALF; i++) begin
      s = {1'b0, r} + {1'b0, v[2*i +: 2]};
      r = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      gap_q   <= '0;
`ifdef RAND_CAND_DIV3_FILTER_EN
      rej_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      gap_q   <= gap_d;
`ifdef RAND_CAND_DIV3_FILTER_EN
      rej_q   <= rej_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    gap_d   = gap_q;
`ifdef RAND_CAND_DIV3_FILTER_EN
    rej_d   = rej_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_GATHER_LO;
      end
      S_GATHER_LO: begin
        cand_d[HALF-1:0] = rand_in | LO_FORCE;
        gap_d            = '0;
        state_d          = S_GATHER_HI;
      end
      S_GATHER_HI: begin
        if (gap_q < GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end else begin
          cand_d[WORD_WIDTH-1:HALF] = rand_in | HI_FORCE;
`ifdef RAND_CAND_DIV3_FILTER_EN
          state_d = S_CHECK;
`else
          state_d = S_PRESENT;
`endif
        end
      end
`ifdef RAND_CAND_DIV3_FILTER_EN
      S_CHECK: begin
        if (mod3(cand_q) == 2'd0) begin
          if (rej_q != '1) rej_d = rej_q + 1'b1;
          state_d = S_GATHER_LO;
        end else begin
          state_d = S_PRESENT;
        end
      end
`endif
      S_PRESENT: begin
        if (cand_ready) state_d = start ? S_GATHER_LO : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cand_valid = (state_q == S_PRESENT);
  assign busy       = (state_q != S_IDLE);
  assign candidate  = cand_q;
`ifdef RAND_CAND_DIV3_FILTER_EN
  assign reject_cnt = rej_q;
`else
  assign reject_cnt = '0;
`endif

endmodule
